sd_rd_bram_writer: RTL and testbench

Upstream stage of the SD-card read path's 1057 x 64 dual-port block RAM. Takes the byte stream recovered from the SD DAT lines and packs each 8 bytes MSB-first into one 64-bit word. Writes each word into RAM port A at consecutive addresses, starting from a commanded base. Counts 512-byte blocks and signals per-block and per-transfer completion to the command sequencer.

---
 rtl/sd_rd_pkg.sv | 16 +
 rtl/sd_byte_packer_64.sv | 42 ++++
 rtl/sd_rd_bram_writer.sv | 132 +++++++++++++
 tb/tb_sd_rd_bram_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_rd_pkg.sv
// Shared definitions for the SD-card read path: BRAM geometry and the
// transfer state encoding used by both the write-side packer and the drain stage.
package sd_rd_pkg;
  localparam int BRAM_AW        = 11;
  localparam int BRAM_DW        = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int WORDS_PER_BLK  = 64;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PACK   = 2'd1,
    FINISH = 2'd2
  } sd_rd_state_e;
endpackage

// File: rtl/sd_byte_packer_64.sv
// Packs eight bytes MSB-first into one 64-bit word; word_rdy_o flags the byte
// that completes a word, and the registered word is presented the cycle after.
module sd_byte_packer_64
  import sd_rd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               vld_i,
  input  logic [7:0]         byte_i,
  output logic [BRAM_DW-1:0] word_o,
  output logic               word_rdy_o
);
  logic [BRAM_DW-1:0]    sreg_q, sreg_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (clr_i) begin
      sreg_d = '0;
      idx_d  = '0;
    end else if (vld_i) begin
      sreg_d = {sreg_q[BRAM_DW-9:0], byte_i};
      idx_d  = idx_q + 1'b1;
    end
  end

  // A clear in the same cycle as the eighth byte suppresses the word.
  assign word_rdy_o = vld_i && !clr_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign word_o     = sreg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end
endmodule

// File: rtl/sd_rd_bram_writer.sv
// Writes packed 64-bit words from the SD read byte stream into BRAM port A,
// tracking address wrap, 512-byte block boundaries and transfer completion.
module sd_rd_bram_writer
  import sd_rd_pkg::*;
#(
  parameter int RAM_DEPTH = 1057,
  parameter int ADDR_W    = BRAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [7:0]         num_blocks,
  input  logic               abort,
  input  logic [7:0]         byte_in,
  input  logic               byte_vld,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [BRAM_DW-1:0] datain_a,
  output logic               wr_a,
  output logic               busy,
  output logic               blk_done,
  output logic               done,
  output logic               aborted
);
  sd_rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_IDX_W-1:0] widx_q, widx_d;
  logic [7:0]            blk_q, blk_d;
  logic                  wr_q, wr_d;
  logic                  blk_done_q, blk_done_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  start_ok, pk_clr, pk_vld, word_rdy;
  logic [BRAM_DW-1:0]    pk_word;

  // busy spans the done/aborted pulse cycle, so a start there is also ignored.
  assign busy     = (state_q != IDLE) || done_q || aborted_q;
  assign start_ok = start && !busy;
  assign pk_clr   = start_ok || (abort && (state_q != IDLE));
  assign pk_vld   = byte_vld && (state_q == PACK);

  sd_byte_packer_64 u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (pk_clr),
    .vld_i     (pk_vld),
    .byte_i    (byte_in),
    .word_o    (pk_word),
    .word_rdy_o(word_rdy)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    widx_d     = widx_q;
    blk_d      = blk_q;
    wr_d       = 1'b0;
    blk_done_d = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    // Address holds through the write cycle and advances on the following edge.
    if (wr_q) begin
      addr_d = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          addr_d  = start_addr;
          blk_d   = num_blocks;
          widx_d  = '0;
          state_d = (num_blocks == 8'd0) ? FINISH : PACK;
        end
      end
      PACK: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (word_rdy) begin
          wr_d   = 1'b1;
          widx_d = widx_q + 1'b1;
          if (widx_q == '1) begin
            blk_done_d = 1'b1;
            blk_d      = blk_q - 8'd1;
            if (blk_q == 8'd1) begin
              state_d = FINISH;
            end
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (abort) begin
          aborted_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      widx_q     <= '0;
      blk_q      <= '0;
      wr_q       <= 1'b0;
      blk_done_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      widx_q     <= widx_d;
      blk_q      <= blk_d;
      wr_q       <= wr_d;
      blk_done_q <= blk_done_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign addr_a   = addr_q;
  assign datain_a = pk_word;
  assign wr_a     = wr_q;
  assign blk_done = blk_done_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
endmodule

// File: tb/tb_sd_rd_bram_writer.sv
// Scoreboard bench for sd_rd_bram_writer: stimulus queues expected writes and
// done/aborted pulses; a negedge monitor pops and compares as the DUT emits them.
module tb_sd_rd_bram_writer;
  localparam int RAM_DEPTH = 1057;
  localparam int ADDR_W    = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [7:0]        num_blocks = '0;
  logic              abort = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_vld = 1'b0;
  logic [ADDR_W-1:0] addr_a;
  logic [63:0]       datain_a;
  logic              wr_a, busy, blk_done, done, aborted;

  sd_rd_bram_writer #(.RAM_DEPTH(RAM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .num_blocks(num_blocks), .abort(abort), .byte_in(byte_in), .byte_vld(byte_vld),
    .addr_a(addr_a), .datain_a(datain_a), .wr_a(wr_a), .busy(busy),
    .blk_done(blk_done), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned       ec;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
    logic              bd;
  } wexp_t;

  wexp_t       wq[$];
  int unsigned dq[$];
  int unsigned aq[$];
  int unsigned ec = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_sh;
  int                m_bidx, m_widx, m_left;
  wexp_t             mon_e;
  int unsigned       mon_t;

  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, ec);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: pulse seen at edge %0d with nothing expected (addr %0d)", nm, ec, addr_a);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_a) begin
        if (wq.size() == 0) unexpected("unexpected_wr");
        else begin
          mon_e = wq.pop_front();
          chk("wr_cycle", 64'(ec), 64'(mon_e.ec));
          chk("wr_addr", 64'(addr_a), 64'(mon_e.addr));
          chk("wr_data", datain_a, mon_e.data);
          chk("wr_blk_done", 64'(blk_done), 64'(mon_e.bd));
        end
      end else if (blk_done) unexpected("blk_done_without_wr");
      if (done) begin
        if (dq.size() == 0) unexpected("unexpected_done");
        else begin
          mon_t = dq.pop_front();
          chk("done_cycle", 64'(ec), 64'(mon_t));
        end
      end
      if (aborted) begin
        if (aq.size() == 0) unexpected("unexpected_aborted");
        else begin
          mon_t = aq.pop_front();
          chk("aborted_cycle", 64'(ec), 64'(mon_t));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] sa, input logic [7:0] nb);
    start = 1'b1; start_addr = sa; num_blocks = nb;
    byte_vld = 1'b1; byte_in = 8'hA5;
    tick();
    start = 1'b0; byte_vld = 1'b0;
    m_addr = sa; m_sh = '0; m_bidx = 0; m_widx = 0; m_left = int'(nb);
    if (nb == 8'd0) dq.push_back(ec + 1);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ab);
    wexp_t w;
    byte_vld = 1'b1; byte_in = b; abort = ab;
    tick();
    byte_vld = 1'b0; abort = 1'b0; start = 1'b0;
    if (ab) aq.push_back(ec);
    else begin
      m_sh = {m_sh[55:0], b};
      m_bidx++;
      if (m_bidx == 8) begin
        w.ec = ec; w.addr = m_addr; w.data = m_sh; w.bd = (m_widx == 63);
        wq.push_back(w);
        m_bidx = 0;
        m_addr = (m_addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : m_addr + 1'b1;
        if (m_widx == 63) begin
          m_widx = 0;
          m_left--;
          if (m_left == 0) dq.push_back(ec + 1);
        end else m_widx++;
      end
    end
  endtask

  task automatic send_stream(input int n, input int gap, input int mul, input int add);
    for (int i = 0; i < n; i++) begin
      send_byte(8'(i * mul + add), 1'b0);
      repeat (gap) tick();
    end
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    aq.push_back(ec);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr_a"}, 64'(addr_a), 64'd0);
    chk({tag, "_datain_a"}, datain_a, 64'd0);
    chk({tag, "_wr_a"}, 64'(wr_a), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_blk_done"}, 64'(blk_done), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_aborted"}, 64'(aborted), 64'd0);
  endtask

  task automatic end_of_xfer_busy();
    chk("busy_at_last_wr", 64'(busy), 64'd1);
    tick();
    chk("busy_at_done", 64'(busy), 64'd1);
    tick();
    chk("busy_after_done", 64'(busy), 64'd0);
    tick();
  endtask

  initial begin
    #1;
    chk_outputs_zero("in_reset");
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_outputs_zero("after_reset");

    // Single block at 0x010, bytes 0x00..0xFF twice, with a stray start mid-block.
    do_start(11'h010, 8'd1);
    for (int i = 0; i < 512; i++) begin
      if (i == 100) begin
        start = 1'b1; start_addr = 11'h300; num_blocks = 8'd5;
      end
      send_byte(8'(i), 1'b0);
      if (i == 7) begin
        chk("first_wr_a", 64'(wr_a), 64'd1);
        chk("first_addr", 64'(addr_a), 64'h010);
        chk("first_word", datain_a, 64'h0001020304050607);
      end
    end
    end_of_xfer_busy();

    // Address wrap from 1056 to 0.
    do_start(11'd1050, 8'd1);
    send_stream(512, 0, 3, 1);
    end_of_xfer_busy();

    // Gapped input, two blocks.
    do_start(11'h100, 8'd2);
    send_stream(1024, 2, 7, 5);
    repeat (4) tick();
    chk("busy_after_gapped", 64'(busy), 64'd0);

    // Abort after 13 bytes: one write only, then a normal transfer.
    do_start(11'h200, 8'd3);
    send_stream(13, 0, 1, 8'h40);
    abort_pulse();
    chk("busy_in_aborted", 64'(busy), 64'd1);
    tick();
    chk("busy_after_abort", 64'(busy), 64'd0);
    tick();
    do_start(11'h000, 8'd1);
    send_stream(512, 0, 5, 9);
    end_of_xfer_busy();

    // Abort coinciding with the eighth byte: no write.
    do_start(11'h050, 8'd1);
    send_stream(7, 0, 1, 8'h11);
    send_byte(8'hEE, 1'b1);
    chk("busy_abort_on_8th", 64'(busy), 64'd1);
    tick();
    chk("busy_after_abort_on_8th", 64'(busy), 64'd0);
    tick();

    // Zero blocks: done two cycles after start, no writes.
    do_start(11'h033, 8'd0);
    tick();
    chk("busy_zero_blk_done", 64'(busy), 64'd1);
    tick();
    chk("busy_zero_blk_after", 64'(busy), 64'd0);
    tick();

    // Reset after 20 words.
    do_start(11'h400, 8'd1);
    send_stream(163, 0, 1, 8'h80);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    byte_vld = 1'b1; byte_in = 8'h5A;
    tick(); tick();
    reset = 1'b0;
    repeat (20) tick();
    byte_vld = 1'b0;
    tick();
    chk("busy_after_reset", 64'(busy), 64'd0);
    chk("addr_after_reset", 64'(addr_a), 64'd0);

    repeat (4) tick();
    chk("writes_outstanding", 64'(wq.size()), 64'd0);
    chk("done_outstanding", 64'(dq.size()), 64'd0);
    chk("aborted_outstanding", 64'(aq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
